// File: rtl/ar0135_dvp_pkg.sv
// Shared types and timing defaults for the AR0135 DVP transmitter.
package ar0135_dvp_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_HBLANK,
    S_VFRONT
  } state_t;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_V_ACTIVE = 960;
  localparam int DEF_H_BLANK  = 16;
  localparam int DEF_V_SYNC   = 8;
  localparam int DEF_V_BACK   = 16;
  localparam int DEF_V_FRONT  = 16;

  function automatic cnt_t last_cnt(input int n);
    return cnt_t'(n - 1);
  endfunction

endpackage

// File: rtl/ar0135_dvp_pattern_gen.sv
// Line/column test pattern source, built only with
// AR0135_DVP_TX_TEST_PATTERN_EN defined.
`ifdef AR0135_DVP_TX_TEST_PATTERN_EN
module ar0135_dvp_pattern_gen
  import ar0135_dvp_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_pix,
  input  logic        i_eol,
  output logic [15:0] o_pix
);

  cnt_t r_col;
  cnt_t r_line;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (i_clr) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (i_eol) begin
      r_col  <= '0;
      r_line <= r_line + cnt_t'(1);
    end else if (i_pix) begin
      r_col  <= r_col + cnt_t'(1);
    end
  end

  assign o_pix = {r_line[7:0], r_col[7:0]};

endmodule
`endif

// File: rtl/ar0135_dvp_tx.sv
// AR0135-style DVP transmitter: 16-bit pixels out as byte pairs, high first.
// Optional internal pattern: define AR0135_DVP_TX_TEST_PATTERN_EN.
module ar0135_dvp_tx
  import ar0135_dvp_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_FRONT  = DEF_V_FRONT
) (
  input  logic        s_clk,
  input  logic        s_rst_n,
  input  logic        en,
  input  logic        test_mode,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_start,
  output logic        underflow
);

  localparam cnt_t L_HA = last_cnt(2 * H_ACTIVE);
  localparam cnt_t L_VA = last_cnt(V_ACTIVE);
  localparam cnt_t L_HB = last_cnt(H_BLANK);
  localparam cnt_t L_VS = last_cnt(V_SYNC);
  localparam cnt_t L_VB = last_cnt(V_BACK);
  localparam cnt_t L_VF = last_cnt(V_FRONT);

  state_t      r_state;
  state_t      w_nxt;
  cnt_t        r_cnt;
  cnt_t        r_line;
  logic        r_phase;
  logic [15:0] r_held;
  logic        r_vsync;
  logic        r_href;
  logic [7:0]  r_data;
  logic        r_fs;
  logic        r_uf;
  logic        w_take;
  logic        w_last_line;
  logic        w_miss;
  logic [15:0] w_pix;

  assign w_take      = (r_state == S_ACTIVE) && !r_phase;
  assign w_last_line = (r_line == L_VA);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (en) w_nxt = S_VSYNC;
      end
      S_VSYNC: begin
        if (r_cnt == L_VS)
          w_nxt = (V_BACK == 0) ? S_ACTIVE : S_VBACK;
      end
      S_VBACK: begin
        if (r_cnt == L_VB) w_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (r_cnt == L_HA) w_nxt = S_HBLANK;
      end
      S_HBLANK: begin
        if (r_cnt == L_HB) begin
          if (!w_last_line)
            w_nxt = S_ACTIVE;
          else
            w_nxt = (V_FRONT == 0) ? S_IDLE : S_VFRONT;
        end
      end
      S_VFRONT: begin
        if (r_cnt == L_VF) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (!s_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  // Per-state cycle counter restarts on every state change.
  always_ff @(posedge s_clk) begin
    if (!s_rst_n)
      r_cnt <= '0;
    else if ((w_nxt != r_state) || (r_state == S_IDLE))
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + cnt_t'(1);
  end

  always_ff @(posedge s_clk) begin
    if (!s_rst_n)
      r_line <= '0;
    else if (r_state == S_VSYNC)
      r_line <= '0;
    else if ((r_state == S_HBLANK) && (r_cnt == L_HB))
      r_line <= r_line + cnt_t'(1);
  end

  always_ff @(posedge s_clk) begin
    if (!s_rst_n)
      r_phase <= 1'b0;
    else if ((r_state == S_ACTIVE) && (w_nxt == S_ACTIVE))
      r_phase <= ~r_phase;
    else
      r_phase <= 1'b0;
  end

`ifdef AR0135_DVP_TX_TEST_PATTERN_EN
  logic        r_tm;
  logic        w_eol;
  logic        w_in_vs;
  logic [15:0] w_pat;

  assign w_eol   = (r_state == S_ACTIVE) && (w_nxt != S_ACTIVE);
  assign w_in_vs = (r_state == S_VSYNC);

  always_ff @(posedge s_clk) begin
    if (!s_rst_n)
      r_tm <= 1'b0;
    else if (r_state == S_IDLE)
      r_tm <= test_mode;
  end

  ar0135_dvp_pattern_gen u_pat (
    .i_clk   (s_clk),
    .i_rst_n (s_rst_n),
    .i_clr   (w_in_vs),
    .i_pix   (w_take),
    .i_eol   (w_eol),
    .o_pix   (w_pat)
  );

  assign s_ready = w_take && !r_tm;
  assign w_miss  = !r_tm && !s_valid;
  assign w_pix   = r_tm ? w_pat : (s_valid ? s_data : 16'h0000);
`else
  logic w_unused;

  assign w_unused = test_mode;
  assign s_ready  = w_take;
  assign w_miss   = !s_valid;
  assign w_pix    = s_valid ? s_data : 16'h0000;
`endif

  // Outputs trail the state by one cycle, so the accepted pixel's
  // high byte appears at the accepting edge.
  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_data  <= 8'h00;
      r_fs    <= 1'b0;
      r_uf    <= 1'b0;
      r_held  <= 16'h0000;
    end else begin
      r_vsync <= (r_state == S_VSYNC);
      r_fs    <= (r_state == S_VSYNC) && (r_cnt == '0);
      r_href  <= (r_state == S_ACTIVE);
      if (w_take) begin
        r_data <= w_pix[15:8];
        r_held <= w_pix;
      end else if (r_state == S_ACTIVE) begin
        r_data <= r_held[7:0];
      end else begin
        r_data <= 8'h00;
      end
      if (w_take && w_miss)
        r_uf <= 1'b1;
    end
  end

  assign dvp_vsync   = r_vsync;
  assign dvp_href    = r_href;
  assign dvp_data    = r_data;
  assign frame_start = r_fs;
  assign underflow   = r_uf;

endmodule

// File: tb/tb_ar0135_dvp_tx.sv
// Scoreboard bench for ar0135_dvp_tx: byte/word queues checked
// by a negedge monitor, plus frame timing checks.
module tb_ar0135_dvp_tx;

  logic        s_clk     = 1'b0;
  logic        s_rst_n   = 1'b0;
  logic        en        = 1'b0;
  logic        test_mode = 1'b0;
  logic [15:0] s_data    = 16'h0000;
  logic        s_valid   = 1'b0;
  logic        s_ready;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;
  logic        frame_start;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  logic [15:0] fifo_q [$];
  logic [7:0]  exp_b  [$];
  logic [15:0] exp_w  [$];

  int   cyc = 0, fs_cnt = 0, byte_cnt = 0, word_cnt = 0;
  int   href_run = 0, vs_run = 0, vs_fall = 0, href_fall = 0;
  bit   prev_href = 0, prev_vs = 0, first_line = 0, rx_ph = 0;
  logic [7:0] rx_hi = 8'h00;
  bit   tp_mode = 0;
  int   tp_ready_cnt = 0;

  logic [15:0] px_a [16] = '{
    16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
    16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978,
    16'h8796, 16'hA5B4, 16'hC3D2, 16'hE1F0,
    16'h1111, 16'h2222, 16'h3333, 16'h4444
  };
  logic [15:0] px_b [8] = '{
    16'hBEEF, 16'hCAFE, 16'h0001, 16'h8000,
    16'h7FFF, 16'h00FF, 16'hFF00, 16'h1357
  };

  ar0135_dvp_tx #(
    .H_ACTIVE (4),
    .V_ACTIVE (2),
    .H_BLANK  (3),
    .V_SYNC   (2),
    .V_BACK   (2),
    .V_FRONT  (1)
  ) dut (
    .s_clk       (s_clk),
    .s_rst_n     (s_rst_n),
    .en          (en),
    .test_mode   (test_mode),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .dvp_vsync   (dvp_vsync),
    .dvp_href    (dvp_href),
    .dvp_data    (dvp_data),
    .frame_start (frame_start),
    .underflow   (underflow)
  );

  always #5 s_clk = ~s_clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout", nm);
  endtask

  task automatic push_px(input logic [15:0] p);
    fifo_q.push_back(p);
    exp_b.push_back(p[15:8]);
    exp_b.push_back(p[7:0]);
    exp_w.push_back(p);
  endtask

  task automatic push_uf();
    exp_b.push_back(8'h00);
    exp_b.push_back(8'h00);
    exp_w.push_back(16'h0000);
  endtask

  task automatic wait_fs(input int lim, output int n);
    n = 0;
    do begin
      @(negedge s_clk);
      n++;
    end while (!frame_start && n < lim);
    if (!frame_start) tmo("wait_frame_start");
  endtask

  task automatic wait_href(input int lim);
    int n = 0;
    do begin
      @(negedge s_clk);
      n++;
    end while (!dvp_href && n < lim);
    if (!dvp_href) tmo("wait_href");
  endtask

  // Upstream FIFO model: pops one entry per accepted handshake.
  always @(negedge s_clk) begin
    s_valid = (fifo_q.size() > 0);
    s_data  = s_valid ? fifo_q[0] : 16'h0000;
    if (s_ready && s_valid) begin
      @(posedge s_clk);
      #1;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      s_valid = (fifo_q.size() > 0);
      s_data  = s_valid ? fifo_q[0] : 16'h0000;
    end
  end

  // Monitor: byte scoreboard, loopback word receiver, frame timing.
  always @(negedge s_clk) begin
    cyc++;
    if (tp_mode && s_ready) tp_ready_cnt++;
    if (!s_rst_n) begin
      href_run   = 0;
      vs_run     = 0;
      prev_href  = 0;
      prev_vs    = 0;
      first_line = 0;
      rx_ph      = 0;
    end else begin
      if (frame_start) fs_cnt++;
      if (dvp_vsync) begin
        vs_run++;
      end else if (prev_vs) begin
        chk("vsync_len", vs_run, 2);
        vs_run     = 0;
        vs_fall    = cyc;
        first_line = 1;
      end
      if (dvp_href) begin
        if (!prev_href) begin
          if (first_line) begin
            chk("vback_gap", cyc - vs_fall, 2);
            first_line = 0;
          end else begin
            chk("hblank_gap", cyc - href_fall, 3);
          end
        end
        href_run++;
        byte_cnt++;
        if (exp_b.size() == 0) tmo("byte_unexpected");
        else chk("byte", int'(dvp_data), int'(exp_b.pop_front()));
        if (!rx_ph) begin
          rx_hi = dvp_data;
        end else begin
          word_cnt++;
          if (exp_w.size() == 0) tmo("word_unexpected");
          else chk("word", int'({rx_hi, dvp_data}), int'(exp_w.pop_front()));
        end
        rx_ph = ~rx_ph;
      end else begin
        if (prev_href) begin
          chk("href_len", href_run, 8);
          href_run  = 0;
          href_fall = cyc;
        end
        rx_ph = 0;
      end
      prev_href = dvp_href;
      prev_vs   = dvp_vsync;
    end
  end

  initial begin
    int n;
    int b0;
    int w0;
    repeat (3) @(negedge s_clk);
    chk("rst_vsync", int'(dvp_vsync), 0);
    chk("rst_href", int'(dvp_href), 0);
    chk("rst_data", int'(dvp_data), 0);
    chk("rst_ready", int'(s_ready), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_uf", int'(underflow), 0);
    s_rst_n = 1'b1;
    repeat (2) @(negedge s_clk);
    chk("idle_vsync", int'(dvp_vsync), 0);

    // Two back-to-back frames, en dropped in frame 2's first line.
    for (int i = 0; i < 16; i++) push_px(px_a[i]);
    en = 1'b1;
    wait_fs(10, n);
    chk("fs1_latency", n, 2);
    wait_fs(60, n);
    chk("frame_period", n, 28);
    wait_href(20);
    repeat (2) @(negedge s_clk);
    en = 1'b0;
    repeat (60) @(negedge s_clk);
    chk("fs_count_2", fs_cnt, 2);
    chk("bytes_2f", byte_cnt, 32);
    chk("words_2f", word_cnt, 16);
    chk("exp_drained_2f", exp_b.size(), 0);
    chk("fifo_drained_2f", fifo_q.size(), 0);
    chk("idle_href", int'(dvp_href), 0);
    chk("uf_clean", int'(underflow), 0);

    // Only one line's worth of pixels: second line underflows.
    for (int i = 0; i < 4; i++) push_px(px_b[i]);
    for (int i = 0; i < 4; i++) push_uf();
    en = 1'b1;
    wait_fs(10, n);
    en = 1'b0;
    repeat (40) @(negedge s_clk);
    chk("uf_set", int'(underflow), 1);
    chk("fs_count_3", fs_cnt, 3);
    chk("bytes_uf", byte_cnt, 48);
    chk("exp_drained_uf", exp_b.size(), 0);
    repeat (10) @(negedge s_clk);
    chk("uf_sticky", int'(underflow), 1);

    // Reset in the middle of an active line.
    for (int i = 0; i < 8; i++) push_px(px_a[i]);
    en = 1'b1;
    wait_fs(10, n);
    wait_href(20);
    repeat (3) @(negedge s_clk);
    s_rst_n = 1'b0;
    @(negedge s_clk);
    chk("mrst_href", int'(dvp_href), 0);
    chk("mrst_ready", int'(s_ready), 0);
    chk("mrst_uf", int'(underflow), 0);
    chk("mrst_data", int'(dvp_data), 0);
    fifo_q.delete();
    exp_b.delete();
    exp_w.delete();
    for (int i = 0; i < 8; i++) push_px(px_b[i]);
    b0 = byte_cnt;
    w0 = word_cnt;
    @(negedge s_clk);
    s_rst_n = 1'b1;
    wait_fs(10, n);
    chk("post_rst_fs_latency", n, 2);
    en = 1'b0;
    repeat (40) @(negedge s_clk);
    chk("post_rst_bytes", byte_cnt - b0, 16);
    chk("post_rst_words", word_cnt - w0, 8);
    chk("post_rst_exp", exp_b.size(), 0);
    chk("fs_count_5", fs_cnt, 5);

`ifdef AR0135_DVP_TX_TEST_PATTERN_EN
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 4; c++) begin
        exp_b.push_back(8'(l));
        exp_b.push_back(8'(c));
        exp_w.push_back({8'(l), 8'(c)});
      end
    end
    test_mode = 1'b1;
    tp_mode   = 1'b1;
    en        = 1'b1;
    wait_fs(10, n);
    en = 1'b0;
    repeat (40) @(negedge s_clk);
    test_mode = 1'b0;
    tp_mode   = 1'b0;
    chk("tp_exp", exp_b.size(), 0);
    chk("tp_ready", tp_ready_cnt, 0);
    chk("tp_uf", int'(underflow), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
